// File: rtl/waterfall_fb_ctrl.sv
// Waterfall framebuffer controller: shares a single-port RAM between the
// LCD pixel fetch (priority) and the ADC row writer, with ring-buffer rows.
module waterfall_fb_ctrl #(
    parameter int COLS        = 320,
    parameter int ROWS        = 240,
    parameter int DW          = 8,
    parameter int AW          = 17,
    parameter int XW          = 9,
    parameter int YW          = 8,
    parameter bit SYNC_COMMIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          disp_req,
    input  logic [XW-1:0] disp_x,
    input  logic [YW-1:0] disp_y,
    output logic [DW-1:0] disp_data,
    output logic          disp_rvalid,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          freeze,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [YW-1:0] newest_row,
    output logic          row_done
);

    typedef enum logic {S_FILL, S_COMMIT} state_e;

    localparam logic [XW:0]   COLS_X   = (XW+1)'(COLS);
    localparam logic [YW:0]   ROWS_Y   = (YW+1)'(ROWS);
    localparam logic [XW-1:0] LAST_COL = XW'(COLS - 1);
    localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);

    state_e        state_q, state_d;
    logic [XW-1:0] wr_col_q, wr_col_d;
    logic [YW-1:0] wr_row_q, wr_row_d;
    logic [YW-1:0] newest_row_q, newest_row_d;
    logic          row_done_q, row_done_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          rd_p1_q, rd_p1_d, rd_i1_q, rd_i1_d;
    logic          rd_p2_q, rd_p2_d, rd_i2_q, rd_i2_d;
    logic [DW-1:0] disp_data_q, disp_data_d;
    logic          disp_rvalid_q, disp_rvalid_d;

    logic          disp_inr;
    logic          disp_sel;
    logic          wr_acc;
    logic          last_col;
    logic          commit;
    logic [YW:0]   phys_row;

    always_comb begin
        disp_inr = ({1'b0, disp_x} < COLS_X) && ({1'b0, disp_y} < ROWS_Y);
        disp_sel = disp_req && disp_inr;
        // newest row is screen top; older rows lie below, wrapping the ring
        if (disp_y > newest_row_q)
            phys_row = {1'b0, newest_row_q} + ROWS_Y - {1'b0, disp_y};
        else
            phys_row = {1'b0, newest_row_q} - {1'b0, disp_y};
        wr_ready = !reset && (state_q == S_FILL) && !freeze && !disp_sel;
        wr_acc   = wr_valid && wr_ready;
        last_col = (wr_col_q == LAST_COL);
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (disp_sel) begin
            ram_addr_d = AW'(phys_row) * COLS_A + AW'(disp_x);
        end else if (wr_acc) begin
            ram_addr_d  = AW'(wr_row_q) * COLS_A + AW'(wr_col_q);
            ram_we_d    = 1'b1;
            ram_wdata_d = wr_data;
        end
        rd_p1_d       = disp_req;
        rd_i1_d       = disp_inr;
        rd_p2_d       = rd_p1_q;
        rd_i2_d       = rd_i1_q;
        disp_rvalid_d = rd_p2_q;
        disp_data_d   = disp_data_q;
        if (rd_p2_q)
            disp_data_d = rd_i2_q ? ram_rdata : '0;
    end

    always_comb begin
        state_d      = state_q;
        wr_col_d     = wr_col_q;
        wr_row_d     = wr_row_q;
        newest_row_d = newest_row_q;
        row_done_d   = 1'b0;
        commit       = 1'b0;
        if (wr_acc)
            wr_col_d = last_col ? '0 : wr_col_q + 1'b1;
        unique case (state_q)
            S_FILL: begin
                if (wr_acc && last_col) begin
                    if (!SYNC_COMMIT || frame_start)
                        commit = 1'b1;
                    else
                        state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (frame_start) begin
                    commit  = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        if (commit) begin
            newest_row_d = wr_row_q;
            wr_row_d     = (wr_row_q == LAST_ROW) ? '0 : wr_row_q + 1'b1;
            row_done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FILL;
            wr_col_q      <= '0;
            wr_row_q      <= '0;
            newest_row_q  <= '0;
            row_done_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            rd_p1_q       <= 1'b0;
            rd_i1_q       <= 1'b0;
            rd_p2_q       <= 1'b0;
            rd_i2_q       <= 1'b0;
            disp_data_q   <= '0;
            disp_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_col_q      <= wr_col_d;
            wr_row_q      <= wr_row_d;
            newest_row_q  <= newest_row_d;
            row_done_q    <= row_done_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            rd_p1_q       <= rd_p1_d;
            rd_i1_q       <= rd_i1_d;
            rd_p2_q       <= rd_p2_d;
            rd_i2_q       <= rd_i2_d;
            disp_data_q   <= disp_data_d;
            disp_rvalid_q <= disp_rvalid_d;
        end
    end

    assign disp_data   = disp_data_q;
    assign disp_rvalid = disp_rvalid_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign newest_row  = newest_row_q;
    assign row_done    = row_done_q;

endmodule

// File: tb/tb_waterfall_fb_ctrl.sv
// Directed bench for waterfall_fb_ctrl: default-size synced instance plus a
// small free-running instance for ring wrap; RAMs modelled here.
module tb_waterfall_fb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, disp_req, wr_valid, freeze;
    logic [8:0]  disp_x;
    logic [7:0]  disp_y;
    logic [7:0]  wr_data, disp_data, ram_wdata, ram_rdata;
    logic        disp_rvalid, wr_ready, ram_we, row_done;
    logic [16:0] ram_addr;
    logic [7:0]  newest_row;

    logic        s_frame_start, s_disp_req, s_wr_valid, s_freeze;
    logic [8:0]  s_disp_x;
    logic [7:0]  s_disp_y;
    logic [7:0]  s_wr_data, s_disp_data, s_ram_wdata, s_ram_rdata;
    logic        s_disp_rvalid, s_wr_ready, s_ram_we, s_row_done;
    logic [16:0] s_ram_addr;
    logic [7:0]  s_newest_row;

    logic [7:0]  mem [0:76799];
    logic [7:0]  smem [0:31];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    waterfall_fb_ctrl u_dut (
        .clk(clk), .reset(rst), .frame_start(frame_start),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_data(disp_data), .disp_rvalid(disp_rvalid),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .freeze(freeze), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .newest_row(newest_row), .row_done(row_done)
    );

    waterfall_fb_ctrl #(.COLS(8), .ROWS(4), .SYNC_COMMIT(1'b0)) u_small (
        .clk(clk), .reset(rst), .frame_start(s_frame_start),
        .disp_req(s_disp_req), .disp_x(s_disp_x), .disp_y(s_disp_y),
        .disp_data(s_disp_data), .disp_rvalid(s_disp_rvalid),
        .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .freeze(s_freeze), .ram_addr(s_ram_addr), .ram_we(s_ram_we),
        .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata),
        .newest_row(s_newest_row), .row_done(s_row_done)
    );

    always @(posedge clk) begin
        if (ram_we && ram_addr < 17'd76800)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < 17'd76800) ? mem[ram_addr] : 8'hxx;
        if (s_ram_we)
            smem[s_ram_addr[4:0]] <= s_ram_wdata;
        s_ram_rdata <= smem[s_ram_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nbad;
        int k;
        int c;
        logic exp_rdy;
        for (int i = 0; i < 76800; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 32; i++) smem[i] = 8'hEE;
        rst = 1'b1;
        frame_start = 0; disp_req = 0; wr_valid = 0; freeze = 0;
        disp_x = 0; disp_y = 0; wr_data = 0;
        s_frame_start = 0; s_disp_req = 0; s_wr_valid = 0; s_freeze = 0;
        s_disp_x = 0; s_disp_y = 0; s_wr_data = 0;
        tick();
        tick();
        chk("rst_addr", ram_addr, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_data", disp_data, 0);
        chk("rst_rvalid", disp_rvalid, 0);
        chk("rst_newest", newest_row, 0);
        chk("rst_rowdone", row_done, 0);
        chk("rst_ready", wr_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", wr_ready, 1);

        // small free-running ring: 5 rows of 8 wrap newest 3 -> 0
        for (int i = 0; i < 40; i++) begin
            s_wr_valid = 1'b1;
            s_wr_data = 8'(i);
            tick();
            if (i == 31) begin
                chk("s_newest3", s_newest_row, 3);
                chk("s_rowdone3", s_row_done, 1);
            end
        end
        s_wr_valid = 1'b0;
        chk("s_newest_wrap", s_newest_row, 0);
        chk("s_rowdone_wrap", s_row_done, 1);
        s_disp_req = 1'b1; s_disp_x = 9'd2; s_disp_y = 8'd1;
        tick();
        s_disp_req = 1'b0;
        chk("s_wrap_addr", s_ram_addr, 26);
        chk("s_wrap_we", s_ram_we, 0);
        tick();
        tick();
        chk("s_wrap_rvalid", s_disp_rvalid, 1);
        chk("s_wrap_data", s_disp_data, 26);

        // row 0, no display traffic
        nbad = 0;
        for (int i = 0; i < 320; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(i);
            #1;
            if (wr_ready !== 1'b1) nbad++;
            tick();
            if (!(ram_we === 1'b1 && ram_addr === 17'(i) &&
                  ram_wdata === 8'(i))) nbad++;
        end
        wr_valid = 1'b0;
        chk("row0_writes", nbad, 0);
        #1;
        chk("commit_wait_ready", wr_ready, 0);
        chk("commit_wait_rowdone", row_done, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("commit0_rowdone", row_done, 1);
        chk("commit0_newest", newest_row, 0);
        tick();
        chk("commit0_pulse_end", row_done, 0);
        chk("commit0_ready", wr_ready, 1);

        // read x=5,y=0 with fixed latency 3
        disp_req = 1'b1; disp_x = 9'd5; disp_y = 8'd0;
        tick();
        disp_req = 1'b0;
        chk("rd_addr", ram_addr, 5);
        chk("rd_we", ram_we, 0);
        tick();
        chk("rd_rvalid_n2", disp_rvalid, 0);
        tick();
        chk("rd_rvalid_n3", disp_rvalid, 1);
        chk("rd_data", disp_data, 5);
        tick();
        chk("rd_rvalid_n4", disp_rvalid, 0);

        // row 1 with a display request every 3rd cycle
        nbad = 0; k = 0; c = 0;
        while (k < 320 && c < 1000) begin
            disp_req = (c % 3 == 0);
            disp_x = 9'd5; disp_y = 8'd0;
            wr_valid = 1'b1;
            wr_data = 8'(k);
            #1;
            exp_rdy = !disp_req;
            if (wr_ready !== exp_rdy) nbad++;
            tick();
            if (exp_rdy) begin
                if (!(ram_we === 1'b1 && ram_addr === 17'(320 + k) &&
                      ram_wdata === 8'(k))) nbad++;
                k++;
            end else begin
                if (!(ram_we === 1'b0 && ram_addr === 17'd5)) nbad++;
            end
            c++;
        end
        wr_valid = 1'b0; disp_req = 1'b0;
        chk("row1_interleave", nbad, 0);
        chk("row1_count", k, 320);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("commit1_newest", newest_row, 1);

        // newest=1, y=2 wraps to physical row 239
        disp_req = 1'b1; disp_x = 9'd7; disp_y = 8'd2;
        tick();
        disp_req = 1'b0;
        chk("wrap_addr", ram_addr, 239 * 320 + 7);
        tick();
        tick();
        chk("wrap_data", disp_data, 8'hEE);

        // row 2, last accept coincident with frame_start
        for (int i = 0; i < 319; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_data = 8'(319);
        frame_start = 1'b1;
        #1;
        chk("coinc_ready", wr_ready, 1);
        tick();
        frame_start = 1'b0;
        wr_valid = 1'b0;
        chk("coinc_rowdone", row_done, 1);
        chk("coinc_newest", newest_row, 2);
        #1;
        chk("coinc_ready_next", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data = 8'h77;
        tick();
        wr_valid = 1'b0;
        chk("row3_first_addr", ram_addr, 960);
        chk("row3_first_we", ram_we, 1);

        // out-of-range request
        disp_req = 1'b1; disp_x = 9'd320; disp_y = 8'd0;
        #1;
        chk("oor_ready", wr_ready, 1);
        tick();
        disp_req = 1'b0;
        chk("oor_no_access", {ram_we, ram_addr}, {1'b0, 17'd960});
        tick();
        tick();
        chk("oor_rvalid", disp_rvalid, 1);
        chk("oor_data", disp_data, 0);

        // reset mid-row at wr_col=100
        for (int i = 0; i < 99; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_wdata", ram_wdata, 0);
        chk("mid_rst_newest", newest_row, 0);
        chk("mid_rst_ready", wr_ready, 0);
        tick();
        rst = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        chk("post_rst_addr", ram_addr, 0);
        chk("post_rst_wdata", {ram_we, ram_wdata}, {1'b1, 8'hA5});

        // freeze stalls the writer, reads continue
        freeze = 1'b1;
        wr_valid = 1'b1;
        wr_data = 8'h11;
        #1;
        chk("freeze_ready", wr_ready, 0);
        disp_req = 1'b1; disp_x = 9'd0; disp_y = 8'd0;
        tick();
        disp_req = 1'b0;
        chk("freeze_rd", {ram_we, ram_addr}, {1'b0, 17'd0});
        tick();
        chk("freeze_no_write", ram_we, 0);
        tick();
        chk("freeze_rvalid", disp_rvalid, 1);
        chk("freeze_data", disp_data, 8'hA5);
        freeze = 1'b0;
        wr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
